// File: rtl/shmem_rr_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// shmem_rr_arbiter
//
// Round-robin arbiter and sequencer that lets N_CORES processor cores share
// one single-port data memory. It grants one core, issues a single memory
// strobe, waits out the fixed read latency, and then returns a one-cycle ack.
// One transaction takes MEM_LAT+3 cycles from the IDLE sampling edge.
//
// Optional feature macro: ARB_LOCK_EN
//   When defined, a core that holds lock[g] during its RESP cycle keeps the
//   port. Its next request wins regardless of the round-robin pointer. When
//   the macro is undefined, lock is ignored.
//
// Ports
//   clock      : single clock, all state changes on posedge
//   reset      : synchronous, active-high
//   req        : per-core request level, held until ack
//   we         : per-core write(1)/read(0), valid while req
//   addr       : packed per-core address, core i = [i*ADDR_W +: ADDR_W]
//   wdata      : packed per-core write data, core i = [i*DATA_W +: DATA_W]
//   lock       : per-core bus-lock request (ARB_LOCK_EN only)
//   grant      : one-hot owner of the memory port, 0 when idle
//   ack        : one-cycle completion pulse to the owner
//   rdata      : read data broadcast, qualified by ack and !we
//   mem_en     : memory strobe, one cycle per transaction
//   mem_we     : memory write enable, valid with mem_en
//   mem_addr   : memory address
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, valid MEM_LAT cycles after mem_en
// ---------------------------------------------------------------------------
module shmem_rr_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_CORES-1:0]         req,
    input  logic [N_CORES-1:0]         we,
    input  logic [N_CORES*ADDR_W-1:0]  addr,
    input  logic [N_CORES*DATA_W-1:0]  wdata,
    input  logic [N_CORES-1:0]         lock,
    output logic [N_CORES-1:0]         grant,
    output logic [N_CORES-1:0]         ack,
    output logic [DATA_W-1:0]          rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int SUM_W = IDX_W + 1;
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [IDX_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]    owner_q,     owner_d;
    logic [N_CORES-1:0]  grant_q,     grant_d;
    logic [N_CORES-1:0]  ack_q,       ack_d;
    logic [DATA_W-1:0]   rdata_q,     rdata_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

`ifdef ARB_LOCK_EN
    logic                lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]    lock_owner_q, lock_owner_d;
`else
    // Lock is not used in the plain round-robin build.
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // ---------------------------------------------------------------------
    // Winner selection: first requesting core at or after rr_ptr, wrapping.
    // The loop runs from the farthest offset down so the nearest one wins.
    // ---------------------------------------------------------------------
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  rr_cand;
    logic [SUM_W-1:0]  rr_sum;

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        rr_cand    = '0;
        for (int j = N_CORES - 1; j >= 0; j--) begin
            rr_sum = SUM_W'(rr_ptr_q) + SUM_W'(j);
            if (rr_sum >= SUM_W'(N_CORES)) begin
                rr_sum = rr_sum - SUM_W'(N_CORES);
            end
            rr_cand = rr_sum[IDX_W-1:0];
            if (req[rr_cand]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_cand;
            end
        end
`ifdef ARB_LOCK_EN
        // A held lock overrides round-robin while its owner keeps requesting.
        if (lock_valid_q && req[lock_owner_q]) begin
            pick_valid = 1'b1;
            pick_idx   = lock_owner_q;
        end
`endif
    end

    // Operand mux for the selected core.
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    logic [IDX_W-1:0] owner_next;
    assign owner_next = (owner_q == IDX_W'(N_CORES - 1)) ? '0 : owner_q + 1'b1;

    // ---------------------------------------------------------------------
    // Next-state and next-output logic.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef ARB_LOCK_EN
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef ARB_LOCK_EN
                // Owner walked away from its lock: fall back to round-robin.
                if (lock_valid_q && !req[lock_owner_q]) begin
                    lock_valid_d = 1'b0;
                end
`endif
                if (pick_valid) begin
                    owner_d     = pick_idx;
                    grant_d     = N_CORES'(1) << pick_idx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = WAIT;
            end

            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    // Memory data is valid on this last wait cycle.
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    ack_d   = grant_q;
                    state_d = RESP;
                end
            end

            RESP: begin
                grant_d = '0;
                state_d = IDLE;
`ifdef ARB_LOCK_EN
                if (lock[owner_q]) begin
                    lock_valid_d = 1'b1;
                    lock_owner_d = owner_q;
                end else begin
                    lock_valid_d = 1'b0;
                    rr_ptr_d     = owner_next;
                end
`else
                rr_ptr_d = owner_next;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled at the same edge.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`endif

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_shmem_rr_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_shmem_rr_arbiter
//
// Two arbiters (MEM_LAT=1 and MEM_LAT=3), each with its own RAM model.
// A transaction-level reference model tracks, per instance, which core owns
// the port and how many cycles have elapsed since the grant. From that it
// derives grant/ack/mem_en/mem_*/rdata every cycle. Directed sequences add
// hand-computed literal checks at the cycles of interest.
// ---------------------------------------------------------------------------
module tb_shmem_rr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Inputs per instance
    logic [N-1:0]    req_s   [2];
    logic [N-1:0]    we_s    [2];
    logic [N*AW-1:0] addr_s  [2];
    logic [N*DW-1:0] wdata_s [2];
    logic [N-1:0]    lock_s  [2];
    // Outputs per instance
    logic [N-1:0]    grant_s     [2];
    logic [N-1:0]    ack_s       [2];
    logic [DW-1:0]   rdata_s     [2];
    logic            mem_en_s    [2];
    logic            mem_we_s    [2];
    logic [AW-1:0]   mem_addr_s  [2];
    logic [DW-1:0]   mem_wdata_s [2];

    // RAM model with a read pipeline; mem_rdata taps stage LAT-1.
    logic [DW-1:0] ram  [2][4096];
    logic [DW-1:0] pipe [2][4];
    logic          ram_loaded = 1'b0;

    int checks = 0;
    int errors = 0;

    shmem_rr_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0)) dut0 (
        .clock(clock), .reset(reset),
        .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .lock(lock_s[0]),
        .grant(grant_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]),
        .mem_en(mem_en_s[0]), .mem_we(mem_we_s[0]), .mem_addr(mem_addr_s[0]),
        .mem_wdata(mem_wdata_s[0]), .mem_rdata(pipe[0][LAT0-1])
    );

    shmem_rr_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1)) dut1 (
        .clock(clock), .reset(reset),
        .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .lock(lock_s[1]),
        .grant(grant_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]),
        .mem_en(mem_en_s[1]), .mem_we(mem_we_s[1]), .mem_addr(mem_addr_s[1]),
        .mem_wdata(mem_wdata_s[1]), .mem_rdata(pipe[1][LAT1-1])
    );

    function automatic logic [DW-1:0] init_val(int a);
        case (a)
            16:      return 16'h1234;
            48:      return 16'hC0DE;
            64:      return 16'h7777;
            default: return 16'(a) ^ 16'h3C00;
        endcase
    endfunction

    always @(posedge clock) begin
        if (!ram_loaded) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < 4096; a++)
                    ram[k][a] <= init_val(a);
            ram_loaded <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (mem_en_s[k] && mem_we_s[k])
                    ram[k][mem_addr_s[k]] <= mem_wdata_s[k];
                pipe[k][0] <= (mem_en_s[k] && !mem_we_s[k]) ? ram[k][mem_addr_s[k]] : 16'hA5A5;
                for (int d = 1; d < 4; d++)
                    pipe[k][d] <= pipe[k][d-1];
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model + per-cycle compare (runs on the negedge: compare the
    // current cycle, then advance the model with this cycle's inputs).
    // -----------------------------------------------------------------------
    int            m_owner [2];
    int            m_age   [2];
    int            m_ptr   [2];
    int            m_lock_g[2];
    bit            m_lock_v[2];
    logic          e_we    [2];
    logic [AW-1:0] e_addr  [2];
    logic [DW-1:0] e_wdata [2];
    logic [DW-1:0] e_rdata [2];
    logic [DW-1:0] ref_mem [2][4096];
    int            lat     [2];
    bit            model_live = 1'b0;

    initial begin
        int eg, ea, w;
        lat[0] = LAT0;
        lat[1] = LAT1;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_age[k] = 0; m_ptr[k] = 0;
            m_lock_g[k] = 0; m_lock_v[k] = 1'b0;
            for (int a = 0; a < 4096; a++) ref_mem[k][a] = init_val(a);
        end
        forever begin
            @(negedge clock);
            if (model_live) begin
                for (int k = 0; k < 2; k++) begin
                    eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
                    ea = (m_owner[k] >= 0 && m_age[k] == lat[k] + 2) ? eg : 0;
                    check($sformatf("m%0d_grant", k), 32'(grant_s[k]), 32'(eg));
                    check($sformatf("m%0d_ack", k), 32'(ack_s[k]), 32'(ea));
                    check($sformatf("m%0d_mem_en", k), 32'(mem_en_s[k]),
                          32'(m_owner[k] >= 0 && m_age[k] == 1));
                    check($sformatf("m%0d_mem_we", k), 32'(mem_we_s[k]), 32'(e_we[k]));
                    check($sformatf("m%0d_mem_addr", k), 32'(mem_addr_s[k]), 32'(e_addr[k]));
                    check($sformatf("m%0d_mem_wdata", k), 32'(mem_wdata_s[k]), 32'(e_wdata[k]));
                    check($sformatf("m%0d_rdata", k), 32'(rdata_s[k]), 32'(e_rdata[k]));
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    m_owner[k] = -1; m_age[k] = 0; m_ptr[k] = 0; m_lock_v[k] = 1'b0;
                    e_we[k] = 1'b0; e_addr[k] = '0; e_wdata[k] = '0; e_rdata[k] = '0;
                end else if (m_owner[k] < 0) begin
                    w = -1;
                    if (LOCK_EN && m_lock_v[k]) begin
                        if (req_s[k][m_lock_g[k]]) w = m_lock_g[k];
                        else m_lock_v[k] = 1'b0;
                    end
                    for (int j = 0; j < N; j++)
                        if (w < 0 && req_s[k][(m_ptr[k] + j) % N]) w = (m_ptr[k] + j) % N;
                    if (w >= 0) begin
                        m_owner[k] = w; m_age[k] = 1;
                        e_we[k]    = we_s[k][w];
                        e_addr[k]  = addr_s[k][w*AW +: AW];
                        e_wdata[k] = wdata_s[k][w*DW +: DW];
                        if (e_we[k]) ref_mem[k][e_addr[k]] = e_wdata[k];
                    end
                end else if (m_age[k] == lat[k] + 2) begin
                    if (LOCK_EN && lock_s[k][m_owner[k]]) begin
                        m_lock_v[k] = 1'b1; m_lock_g[k] = m_owner[k];
                    end else begin
                        m_lock_v[k] = 1'b0; m_ptr[k] = (m_owner[k] + 1) % N;
                    end
                    m_owner[k] = -1; m_age[k] = 0;
                end else begin
                    m_age[k]++;
                    if (m_age[k] == lat[k] + 2 && !e_we[k]) e_rdata[k] = ref_mem[k][e_addr[k]];
                end
            end
            if (reset) model_live = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    logic [N-1:0] ack_seen [2];
    logic [N-1:0] hold0 = '0;   // cores on instance 0 that keep req across ack

    // Advance one cycle; a core whose ack was visible drops req.
    task automatic tick();
        @(negedge clock);
        ack_seen[0] = ack_s[0];
        ack_seen[1] = ack_s[1];
        @(posedge clock);
        #2;
        req_s[0] = req_s[0] & ~(ack_seen[0] & ~hold0);
        req_s[1] = req_s[1] & ~ack_seen[1];
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_core(int k, int i, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        we_s[k][i]             = w;
        addr_s[k][i*AW +: AW]  = a;
        wdata_s[k][i*DW +: DW] = d;
        req_s[k][i]            = 1'b1;
    endtask

    task automatic wait_idle(int k);
        int n = 0;
        while ((req_s[k] != '0 || grant_s[k] != '0) && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("drain%0d", k), 32'({grant_s[k], req_s[k]}), 32'(0));
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_s[k] = '0; we_s[k] = '0; addr_s[k] = '0; wdata_s[k] = '0; lock_s[k] = '0;
        end
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;

        // Reset state
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_grant%0d", k), 32'(grant_s[k]), 32'(0));
            check($sformatf("rst_ack%0d", k), 32'(ack_s[k]), 32'(0));
            check($sformatf("rst_rdata%0d", k), 32'(rdata_s[k]), 32'(0));
            check($sformatf("rst_mem_en%0d", k), 32'(mem_en_s[k]), 32'(0));
            check($sformatf("rst_mem_addr%0d", k), 32'(mem_addr_s[k]), 32'(0));
        end

        // Single read: core 2, addr 0x010 holds 0x1234
        set_core(0, 2, 1'b0, 12'h010, 16'h0);
        tick();
        check("rd_mem_en", 32'(mem_en_s[0]), 32'(1));
        check("rd_mem_addr", 32'(mem_addr_s[0]), 32'h010);
        check("rd_mem_we", 32'(mem_we_s[0]), 32'(0));
        check("rd_grant", 32'(grant_s[0]), 32'b0100);
        ticks(2);
        check("rd_ack", 32'(ack_s[0]), 32'b0100);
        check("rd_rdata", 32'(rdata_s[0]), 32'h1234);
        tick();
        check("rd_grant_idle", 32'(grant_s[0]), 32'(0));
        check("rd_ack_done", 32'(ack_s[0]), 32'(0));
        wait_idle(0);

        // All four cores at once after reset: order 0,1,2,3, every 4 cycles
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_core(0, i, 1'b0, 12'(32 + i), 16'h0);
        for (int i = 0; i < N; i++) begin
            tick();
            check($sformatf("rr_grant_%0d", i), 32'(grant_s[0]), 32'(1 << i));
            ticks(3);
        end
        wait_idle(0);
        set_core(0, 1, 1'b0, 12'h030, 16'h0);
        tick();
        check("solo_grant1", 32'(grant_s[0]), 32'b0010);
        ticks(2);
        check("solo_rdata", 32'(rdata_s[0]), 32'hC0DE);
        wait_idle(0);

        // Write then read back
        set_core(0, 0, 1'b1, 12'h005, 16'hBEEF);
        ticks(3);
        check("wr_ack", 32'(ack_s[0]), 32'b0001);
        check("wr_rdata_kept", 32'(rdata_s[0]), 32'hC0DE);
        wait_idle(0);
        set_core(0, 3, 1'b0, 12'h005, 16'h0);
        tick();
        check("rb_grant", 32'(grant_s[0]), 32'b1000);
        ticks(2);
        check("rb_ack", 32'(ack_s[0]), 32'b1000);
        check("rb_rdata", 32'(rdata_s[0]), 32'hBEEF);
        wait_idle(0);

        // Reset during ISSUE of a core 1 read (rr_ptr is 1 beforehand)
        set_core(0, 0, 1'b0, 12'h010, 16'h0);
        wait_idle(0);
        set_core(0, 1, 1'b0, 12'h030, 16'h0);
        tick();
        check("rst_issue_en", 32'(mem_en_s[0]), 32'(1));
        reset    = 1'b1;
        req_s[0] = '0;
        tick();
        reset = 1'b0;
        check("rst_mid_grant", 32'(grant_s[0]), 32'(0));
        check("rst_mid_mem_en", 32'(mem_en_s[0]), 32'(0));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_mid_noack_%0d", i), 32'(ack_s[0]), 32'(0));
            tick();
        end
        set_core(0, 0, 1'b0, 12'h021, 16'h0);
        set_core(0, 1, 1'b0, 12'h022, 16'h0);
        tick();
        check("rst_pair_first", 32'(grant_s[0]), 32'b0001);
        ticks(4);
        check("rst_pair_second", 32'(grant_s[0]), 32'b0010);
        wait_idle(0);

        // MEM_LAT=3 read on instance 1, req dropped during WAIT
        set_core(1, 1, 1'b0, 12'h040, 16'h0);
        tick();
        check("l3_mem_en", 32'(mem_en_s[1]), 32'(1));
        check("l3_mem_addr", 32'(mem_addr_s[1]), 32'h040);
        tick();
        req_s[1][1] = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("l3_en_low_t%0d", i), 32'(mem_en_s[1]), 32'(0));
            check($sformatf("l3_no_ack_t%0d", i), 32'(ack_s[1]), 32'(0));
            tick();
        end
        check("l3_ack", 32'(ack_s[1]), 32'b0010);
        check("l3_rdata", 32'(rdata_s[1]), 32'h7777);
        tick();
        check("l3_grant_idle", 32'(grant_s[1]), 32'(0));
        tick();
        check("l3_stays_idle", 32'(grant_s[1]), 32'(0));

`ifdef ARB_LOCK_EN
        // Lock: core 2 keeps the port for three transactions (rr_ptr is 2)
        set_core(0, 2, 1'b0, 12'h020, 16'h0);
        set_core(0, 0, 1'b0, 12'h021, 16'h0);
        lock_s[0] = 4'b0100;
        hold0     = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lock_grant_%0d", i), 32'(grant_s[0]), 32'b0100);
            if (i < 2) ticks(3);
        end
        ticks(2);
        check("lock_last_ack", 32'(ack_s[0]), 32'b0100);
        lock_s[0]   = '0;
        hold0       = '0;
        req_s[0][2] = 1'b0;
        ticks(2);
        check("lock_release", 32'(grant_s[0]), 32'b0001);
        wait_idle(0);
`endif

        ticks(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
